// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data path.
// One outstanding transaction; data has priority, with bounded fetch starvation.
module mem_port_arbiter #(
  parameter  int ADDR_W     = 32,
  parameter  int DATA_W     = 32,
  parameter  int MAX_STARVE = 4,
  localparam int STRB_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              owner,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_data_win;
  logic                w_fetch_win;
  logic                w_rsp_done;
  logic                w_stray;
  logic [3:0]          r_starve_cnt;
  logic                r_if_gnt;
  logic                r_if_rvalid;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_d_gnt;
  logic                r_d_rvalid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_m_req;
  logic                r_m_we;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [STRB_W-1:0]   r_m_wstrb;
  logic                r_busy;
  logic                r_owner;
  logic                r_proto_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_win  = 1'b0;
    w_fetch_win = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Fetch only overtakes a pending data request once it has been starved enough.
        if (d_req && !(if_req && (r_starve_cnt == STARVE_LIM))) w_data_win = 1'b1;
        else if (if_req)                                        w_fetch_win = 1'b1;
        if (w_data_win || w_fetch_win) w_state_nxt = S_WAIT_GNT;
      end
      S_WAIT_GNT: if (m_gnt) w_state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (m_rvalid) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stray = (m_rvalid && (r_state != S_WAIT_RSP)) || (m_gnt && !r_m_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_if_gnt     <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_d_gnt      <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= '0;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_wstrb    <= '0;
      r_busy       <= 1'b0;
      r_owner      <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_if_gnt    <= w_fetch_win;
      r_d_gnt     <= w_data_win;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_stray) r_proto_err <= 1'b1;

      if (w_data_win) begin
        r_m_req   <= 1'b1;
        r_m_we    <= d_we;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
        r_m_wstrb <= d_wstrb;
        r_owner   <= 1'b1;
        if (!if_req)                        r_starve_cnt <= '0;
        else if (r_starve_cnt < STARVE_LIM) r_starve_cnt <= r_starve_cnt + 4'd1;
      end else if (w_fetch_win) begin
        r_m_req      <= 1'b1;
        r_m_we       <= 1'b0;
        r_m_addr     <= if_addr;
        r_m_wdata    <= '0;
        r_m_wstrb    <= '0;
        r_owner      <= 1'b0;
        r_starve_cnt <= '0;
      end

      if ((r_state == S_WAIT_GNT) && m_gnt) r_m_req <= 1'b0;

      // Command fields stay latched after the response, so m_we still marks a write here.
      if (w_rsp_done) begin
        if (r_owner) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= r_m_we ? '0 : m_rdata;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= m_rdata;
        end
      end
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign m_req     = r_m_req;
  assign m_we      = r_m_we;
  assign m_addr    = r_m_addr;
  assign m_wdata   = r_m_wdata;
  assign m_wstrb   = r_m_wstrb;
  assign busy      = r_busy;
  assign owner     = r_owner;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, write, starvation, wait states,
// reset mid-transaction and stray-grant error detection.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic              m_gnt, m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              busy, owner, proto_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .owner(owner), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    tick(); tick();
    checks++; if ({m_req, m_we, if_gnt, if_rvalid, d_gnt, d_rvalid, busy, owner, proto_err} !== 9'b0)
      $display("FAIL reset_ctrl: got %b expected 0", {m_req, m_we, if_gnt, if_rvalid, d_gnt, d_rvalid, busy, owner, proto_err});
    else passed++;
    checks++; if ({m_addr, m_wdata, m_wstrb, if_rdata, d_rdata} !== '0)
      $display("FAIL reset_data: got %h expected 0", {m_addr, m_wdata, m_wstrb, if_rdata, d_rdata});
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h10;
    tick(); // cycle 1
    checks++; if ({if_gnt, m_req, m_we, owner, busy, d_gnt} !== 6'b110010)
      $display("FAIL fetch_c1_ctrl: got %b expected 110010", {if_gnt, m_req, m_we, owner, busy, d_gnt});
    else passed++;
    checks++; if (m_addr !== 32'h10 || m_wdata !== '0 || m_wstrb !== '0)
      $display("FAIL fetch_c1_cmd: got %h/%h/%h expected 10/0/0", m_addr, m_wdata, m_wstrb);
    else passed++;
    m_gnt = 1;
    tick(); // cycle 2
    if_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h00500093;
    checks++; if ({if_gnt, m_req, busy} !== 3'b001)
      $display("FAIL fetch_c2: got %b expected 001", {if_gnt, m_req, busy});
    else passed++;
    tick(); // cycle 3
    m_rvalid = 0; m_rdata = '0;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || busy !== 1'b0)
      $display("FAIL fetch_c3: got rvalid=%b rdata=%h busy=%b expected 1/00500093/0", if_rvalid, if_rdata, busy);
    else passed++;
    checks++; if ({d_gnt, d_rvalid} !== 2'b00 || d_rdata !== '0)
      $display("FAIL fetch_d_quiet: got %b %h expected 00 0", {d_gnt, d_rvalid}, d_rdata);
    else passed++;
    tick(); // cycle 4
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h00500093)
      $display("FAIL fetch_c4_hold: got %b %h expected 0 00500093", if_rvalid, if_rdata);
    else passed++;
  endtask

  task automatic test_data_write();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    tick(); // cycle 1
    checks++; if ({d_gnt, if_gnt, m_req, m_we, owner} !== 5'b10111)
      $display("FAIL write_c1_ctrl: got %b expected 10111", {d_gnt, if_gnt, m_req, m_we, owner});
    else passed++;
    checks++; if (m_addr !== 32'h80 || m_wdata !== 32'hDEADBEEF || m_wstrb !== 4'hF)
      $display("FAIL write_c1_cmd: got %h/%h/%h expected 80/DEADBEEF/F", m_addr, m_wdata, m_wstrb);
    else passed++;
    m_gnt = 1;
    tick(); // cycle 2
    d_req = 0; d_we = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D;
    tick(); // cycle 3
    m_rvalid = 0; m_rdata = '0;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== '0 || if_rvalid !== 1'b0)
      $display("FAIL write_rsp: got rvalid=%b rdata=%h if_rvalid=%b expected 1/0/0", d_rvalid, d_rdata, if_rvalid);
    else passed++;
    tick();
    checks++; if (d_rvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL write_after: got rvalid=%b busy=%b expected 0/0", d_rvalid, busy);
    else passed++;
  endtask

  task automatic test_starvation();
    logic [9:0] exp_order;
    exp_order = 10'b0111101111; // bit i = 1 means data expected for grant i (LSB first)
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int i = 0; i < 10; i++) begin
      tick(); // cycle 1 of transaction
      checks++; if (d_gnt !== exp_order[i] || if_gnt !== !exp_order[i])
        $display("FAIL starve_order[%0d]: got d_gnt=%b if_gnt=%b expected d_gnt=%b", i, d_gnt, if_gnt, exp_order[i]);
      else passed++;
      m_gnt = 1;
      tick();
      m_gnt = 0; m_rvalid = 1; m_rdata = 32'(i);
      tick();
      m_rvalid = 0;
    end
    if_req = 0; d_req = 0;
    tick();
  endtask

  task automatic test_wait_states();
    int n_gnt = 0;
    int n_rv  = 0;
    d_req = 1; d_we = 0; d_addr = 32'h44;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (cyc == 2) d_req = 0;
      if (d_gnt) n_gnt++;
      if (d_rvalid) n_rv++;
      if (cyc <= 4) begin
        checks++; if (m_req !== 1'b1 || m_addr !== 32'h44 || m_we !== 1'b0)
          $display("FAIL wait_cmd_c%0d: got req=%b addr=%h we=%b expected 1/44/0", cyc, m_req, m_addr, m_we);
        else passed++;
      end
      checks++; if (busy !== (cyc <= 10))
        $display("FAIL wait_busy_c%0d: got %b expected %b", cyc, busy, (cyc <= 10));
      else passed++;
      if (cyc == 11) begin
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678)
          $display("FAIL wait_rsp: got %b %h expected 1 12345678", d_rvalid, d_rdata);
        else passed++;
      end
      m_gnt    = (cyc == 4);
      m_rvalid = (cyc == 10);
      m_rdata  = (cyc == 10) ? 32'h12345678 : '0;
    end
    checks++; if (n_gnt != 1 || n_rv != 1 || proto_err !== 1'b0)
      $display("FAIL wait_counts: got gnt=%0d rvalid=%0d err=%b expected 1/1/0", n_gnt, n_rv, proto_err);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    d_req = 1; d_we = 0; d_addr = 32'h20;
    tick(); // cycle 1
    m_gnt = 1;
    tick(); // cycle 2, WAIT_RSP
    d_req = 0; m_gnt = 0;
    #2 reset = 1'b1;
    #1;
    checks++; if ({m_req, m_we, if_gnt, if_rvalid, d_gnt, d_rvalid, busy, owner, proto_err} !== 9'b0 ||
                  {m_addr, if_rdata, d_rdata} !== '0)
      $display("FAIL midop_reset: got %b addr=%h expected all 0",
               {m_req, m_we, if_gnt, if_rvalid, d_gnt, d_rvalid, busy, owner, proto_err}, m_addr);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
    m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    tick();
    m_rvalid = 0; m_rdata = '0;
    checks++; if ({d_rvalid, if_rvalid, busy, proto_err} !== 4'b0001)
      $display("FAIL midop_late_rsp: got %b expected 0001", {d_rvalid, if_rvalid, busy, proto_err});
    else passed++;
  endtask

  task automatic test_stray_grant();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (proto_err !== 1'b0)
      $display("FAIL stray_cleared: got %b expected 0", proto_err);
    else passed++;
    m_gnt = 1;
    tick();
    m_gnt = 0;
    checks++; if (proto_err !== 1'b1 || busy !== 1'b0 || m_req !== 1'b0)
      $display("FAIL stray_set: got err=%b busy=%b req=%b expected 1/0/0", proto_err, busy, m_req);
    else passed++;
    tick(); tick(); tick();
    checks++; if (proto_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL stray_sticky: got err=%b busy=%b expected 1/0", proto_err, busy);
    else passed++;
    reset = 1'b1;
    #1;
    checks++; if (proto_err !== 1'b0)
      $display("FAIL stray_reset_clear: got %b expected 0", proto_err);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_starvation();
    test_wait_states();
    test_reset_mid_op();
    test_stray_grant();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch and the data load/store path. It sits between `simple_rv32i` (fetch side plus the future load/store unit) and one single-ported memory. It allows one outstanding transaction at a time, gives data accesses fixed priority, and bounds fetch starvation. All outputs are registered.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `STRB_W = DATA_W/8`.
- `MAX_STARVE`, default 4: consecutive data grants while fetch is pending before fetch wins. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  one-cycle pulse: fetch request accepted.
- `if_rvalid`  out  1  one-cycle pulse: fetch response.
- `if_rdata`  out  DATA_W  fetch data; valid with `if_rvalid`, held afterwards.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_wstrb`  in  STRB_W  byte enables for writes.
- `d_gnt`  out  1  one-cycle pulse: data request accepted.
- `d_rvalid`  out  1  one-cycle pulse: read data, or write acknowledge.
- `d_rdata`  out  DATA_W  read data; 0 for writes, held afterwards.
- `m_req`  out  1  memory request.
- `m_we`, `m_addr`, `m_wdata`, `m_wstrb`  out  1/ADDR_W/DATA_W/STRB_W  memory command fields; stable while `m_req` = 1.
- `m_gnt`  in  1  memory accepts the command in a cycle with `m_req` = 1.
- `m_rvalid`  in  1  memory response; exactly one per accepted command, for reads and writes.
- `m_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  requester of the current transaction: 0 = fetch, 1 = data.
- `proto_err`  out  1  sticky error flag; cleared only by `reset`.

## Operation
States: IDLE, WAIT_GNT, WAIT_RSP.

- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise choose a winner:
    - Data wins if `d_req` = 1, unless `if_req` = 1 and `starve_cnt` = `MAX_STARVE`. In that case fetch wins.
    - Fetch wins if only `if_req` = 1.
  - Latch the winner's command fields into the `m_*` registers. Fetch commands use `m_we` = 0, `m_wdata` = 0, `m_wstrb` = 0.
  - Set `owner` and go to WAIT_GNT.
- **WAIT_GNT**
  - `m_req` = 1, and the winner's `x_gnt` is high for the first cycle of this state only.
  - On `m_gnt` = 1: drop `m_req` at the next edge and go to WAIT_RSP.
- **WAIT_RSP**
  - On `m_rvalid` = 1: the next cycle pulses `owner`'s `x_rvalid` and loads `x_rdata` from `m_rdata`. For a data write, `d_rdata` is loaded with 0.
  - Return to IDLE. The first new arbitration is sampled in the cycle after the `m_rvalid` cycle.
- **Starvation counter** (`starve_cnt`, 4 bits)
  - Increments on each data win while `if_req` = 1, saturating at `MAX_STARVE`.
  - Clears on a fetch win.
  - Clears on a data win while `if_req` = 0.
- **proto_err** is set by either of:
  - `m_rvalid` = 1 in IDLE or WAIT_GNT (a stray response);
  - `m_gnt` = 1 while `m_req` = 0.
  
  Neither event changes state.
- **Non-owner isolation**: requests from the non-owner are ignored while `busy` = 1. They stay pending and are not dropped.

## Timing
- **Reset**: asynchronous and immediate, including mid-transaction.
  - State goes to IDLE.
  - All outputs are 0: `m_*`, `x_gnt`, `x_rvalid`, `x_rdata`, `busy`, `owner`, `proto_err`.
  - `starve_cnt` is 0.
  - Any in-flight transaction is abandoned. A late `m_rvalid` after reset sets `proto_err`.
- **Minimum transaction latency**, counted from the request being sampled in IDLE (cycle 0):
  - cycle 1: `m_req` and `x_gnt`.
  - cycle 1: `m_gnt` sampled, if returned immediately.
  - cycle 2: `m_rvalid`.
  - cycle 3: `x_rvalid`.
  - cycle 3: IDLE; the next arbitration happens in this cycle.
  
  Peak throughput is therefore one transaction per 3 cycles.
- **Requester handshake**: a requester may deassert `req`, or present a new command, from the cycle after its `gnt` pulse. The arbiter never samples a stale request, because IDLE is re-entered at least 2 cycles after `gnt`.
- **Wait states**: `m_gnt` and `m_rvalid` may each be delayed by any number of cycles. All outputs hold steady while waiting.
- **Simultaneous requests** in IDLE: resolved by the priority and starvation rule above, in the same cycle they are sampled.

## Test plan
- **Single fetch**: `if_req`, addr 0x10; memory returns `m_gnt` immediately and `m_rdata` = 0x00500093 one cycle later → `if_gnt` in cycle 1, `if_rvalid` with `if_rdata` = 0x00500093 in cycle 3, `d_*` outputs stay 0.
- **Data write**: `d_we` = 1, addr 0x80, wdata 0xDEADBEEF, wstrb 0xF → `m_we` = 1 with matching fields, `d_rvalid` pulse, `d_rdata` = 0.
- **Starvation**: `if_req` and `d_req` held high continuously, `MAX_STARVE` = 4 → grant order D, D, D, D, F, D, D, D, D, F, …
- **Wait states**: `m_gnt` delayed 3 cycles and `m_rvalid` delayed 5 cycles → `m_req` and command fields stable throughout, exactly one `x_gnt` and one `x_rvalid`, `busy` = 1 until the response.
- **Reset mid-op**: assert `reset` in WAIT_RSP, then `m_rvalid` arrives after `reset` is released → all outputs 0 during reset, no `x_rvalid` pulse, `proto_err` = 1.
- **Stray grant**: `m_gnt` = 1 in IDLE → `proto_err` = 1 and stays 1 until `reset`; state remains IDLE.
